// File: rtl/fft8_result_unloader.sv
// Ping-pong frame buffer for the 8-point DIF FFT: captures a parallel 8-lane frame per
// handshake and streams it out one complex bin per beat, optionally undoing bit reversal.
module fft8_result_unloader #(
  parameter int DATA_W = 32,
  parameter bit BITREV = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*DATA_W-1:0] in_real,
  input  logic [8*DATA_W-1:0] in_imag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_real,
  output logic [DATA_W-1:0]   out_imag,
  output logic [2:0]          out_index,
  output logic                out_last
);

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_t;

  bank_state_t       bank_q [2];
  bank_state_t       bank_d [2];
  logic [DATA_W-1:0] real_q [2][8];
  logic [DATA_W-1:0] real_d [2][8];
  logic [DATA_W-1:0] imag_q [2][8];
  logic [DATA_W-1:0] imag_d [2][8];
  logic              wp_q, wp_d;
  logic              rp_q, rp_d;
  logic [2:0]        beat_q, beat_d;

  logic              capture;
  logic              out_fire;
  logic [2:0]        lane;

  function automatic logic [2:0] bitrev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  // in_ready looks only at registered bank state, so a release never opens the input the same cycle
  assign in_ready  = (bank_q[wp_q] == BANK_EMPTY) && !rst;
  assign out_valid = (bank_q[rp_q] == BANK_FULL);
  assign capture   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign lane      = BITREV ? bitrev3(beat_q) : beat_q;
  assign out_real  = real_q[rp_q][lane];
  assign out_imag  = imag_q[rp_q][lane];
  assign out_index = beat_q;
  assign out_last  = (beat_q == 3'd7);

  always_comb begin
    bank_d = bank_q;
    real_d = real_q;
    imag_d = imag_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    beat_d = beat_q;

    if (capture) begin
      for (int k = 0; k < 8; k++) begin
        real_d[wp_q][k] = in_real[k*DATA_W +: DATA_W];
        imag_d[wp_q][k] = in_imag[k*DATA_W +: DATA_W];
      end
      bank_d[wp_q] = BANK_FULL;
      wp_d         = ~wp_q;
    end

    // capture targets an empty bank, release a full one, so both may land on the same edge
    if (out_fire) begin
      beat_d = beat_q + 3'd1;
      if (beat_q == 3'd7) begin
        bank_d[rp_q] = BANK_EMPTY;
        rp_d         = ~rp_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        bank_q[b] <= BANK_EMPTY;
        for (int k = 0; k < 8; k++) begin
          real_q[b][k] <= '0;
          imag_q[b][k] <= '0;
        end
      end
      wp_q   <= 1'b0;
      rp_q   <= 1'b0;
      beat_q <= 3'd0;
    end else begin
      bank_q <= bank_d;
      real_q <= real_d;
      imag_q <= imag_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      beat_q <= beat_d;
    end
  end

endmodule

// File: tb/tb_fft8_result_unloader.sv
// Bench for fft8_result_unloader: queue-based frame model checked every cycle, plus
// literal expectations for bit-reverse order, ping-pong timing, reset and a narrow direct-order build.
module tb_fft8_result_unloader;

  localparam int W  = 32;
  localparam int NW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid;
  logic            in_ready;
  logic [8*W-1:0]  in_real;
  logic [8*W-1:0]  in_imag;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_real;
  logic [W-1:0]    out_imag;
  logic [2:0]      out_index;
  logic            out_last;

  logic            n_in_valid;
  logic            n_in_ready;
  logic [8*NW-1:0] n_in_real;
  logic [8*NW-1:0] n_in_imag;
  logic            n_out_valid;
  logic            n_out_ready;
  logic [NW-1:0]   n_out_real;
  logic [NW-1:0]   n_out_imag;
  logic [2:0]      n_out_index;
  logic            n_out_last;

  always #5 clk = ~clk;

  fft8_result_unloader #(.DATA_W(W), .BITREV(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
    .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
    .out_index(out_index), .out_last(out_last)
  );

  fft8_result_unloader #(.DATA_W(NW), .BITREV(1'b0)) dut_n (
    .clk(clk), .rst(rst),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_real(n_in_real), .in_imag(n_in_imag),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_real(n_out_real), .out_imag(n_out_imag),
    .out_index(n_out_index), .out_last(n_out_last)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model: frames held by the unloader, oldest first, plus the beat within the head frame
  logic [8*W-1:0] mq_re [$];
  logic [8*W-1:0] mq_im [$];
  int             mbeat = 0;
  int             brmap [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  logic [8*W-1:0] stim_re [$];
  logic [8*W-1:0] stim_im [$];
  logic [W-1:0]   obs_re [$];
  logic [W-1:0]   obs_im [$];
  int             obs_cyc [$];
  int             acc_cyc [$];
  bit             in_taken = 1'b0;
  int             pat [6] = '{1, 0, 0, 1, 0, 1};
  int             pat_idx = 0;

  logic [8*W-1:0] head_re, head_im;
  logic           exp_rdy, exp_vld, cin, cout;
  int             lane;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [8*W-1:0] rnd_frame();
    logic [8*W-1:0] f;
    for (int k = 0; k < 8; k++) f[k*W +: W] = $urandom;
    return f;
  endfunction

  always @(negedge clk) begin
    cyc++;
    in_taken = 1'b0;
    if (rst) begin
      mq_re.delete();
      mq_im.delete();
      mbeat = 0;
      checkOutput("rst_in_ready",  64'(in_ready),  64'd0);
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_out_real",  64'(out_real),  64'd0);
      checkOutput("rst_out_index", 64'(out_index), 64'd0);
      checkOutput("rst_out_last",  64'(out_last),  64'd0);
    end else begin
      exp_rdy = (mq_re.size() < 2);
      exp_vld = (mq_re.size() > 0);
      checkOutput("in_ready",  64'(in_ready),  64'(exp_rdy));
      checkOutput("out_valid", 64'(out_valid), 64'(exp_vld));
      if (exp_vld) begin
        head_re = mq_re[0];
        head_im = mq_im[0];
        lane    = brmap[mbeat];
        checkOutput("out_real",  64'(out_real),  64'(head_re[lane*W +: W]));
        checkOutput("out_imag",  64'(out_imag),  64'(head_im[lane*W +: W]));
        checkOutput("out_index", 64'(out_index), 64'(mbeat));
        checkOutput("out_last",  64'(out_last),  64'(mbeat == 7));
      end
      cin  = in_valid && exp_rdy;
      cout = exp_vld && out_ready;
      if (cout) begin
        obs_re.push_back(out_real);
        obs_im.push_back(out_imag);
        obs_cyc.push_back(cyc);
        if (mbeat == 7) begin
          void'(mq_re.pop_front());
          void'(mq_im.pop_front());
          mbeat = 0;
        end else begin
          mbeat++;
        end
      end
      if (cin) begin
        mq_re.push_back(in_real);
        mq_im.push_back(in_imag);
        acc_cyc.push_back(cyc);
      end
      in_taken = cin;
    end
  end

  // mode 0: out_ready=1; mode 1: 1,0,0,1,0,1 pattern; mode 2: random both sides
  task automatic applyStimulus(input int mode, input int stop_beat, input int maxcyc);
    int n;
    for (n = 0; n < maxcyc; n++) begin
      if (stop_beat >= 0 && mbeat == stop_beat && mq_re.size() > 0) break;
      if (stop_beat < 0 && stim_re.size() == 0 && mq_re.size() == 0) break;
      in_valid = (stim_re.size() > 0) && (mode != 2 || $urandom_range(0, 3) != 0);
      if (stim_re.size() > 0) begin
        in_real = stim_re[0];
        in_imag = stim_im[0];
      end
      case (mode)
        1:       begin out_ready = pat[pat_idx % 6] != 0; pat_idx++; end
        2:       out_ready = $urandom_range(0, 3) != 0;
        default: out_ready = 1'b1;
      endcase
      @(posedge clk);
      #1;
      if (in_taken) begin
        void'(stim_re.pop_front());
        void'(stim_im.pop_front());
      end
    end
    checkOutput("drain_timeout", 64'(n >= maxcyc), 64'd0);
    in_valid = 1'b0;
  endtask

  task automatic clear_logs();
    obs_re.delete();
    obs_im.delete();
    obs_cyc.delete();
    acc_cyc.delete();
  endtask

  initial begin
    logic [8*W-1:0] f_re, f_im, f2_re;
    logic [W-1:0]   lit_re [8];
    logic [W-1:0]   lit_im [8];
    logic [NW-1:0]  lit_n  [8];

    in_valid = 1'b0; in_real = '0; in_imag = '0; out_ready = 1'b1;
    n_in_valid = 1'b0; n_in_real = '0; n_in_imag = '0; n_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] bit-reverse order");
    lit_re = '{100, 104, 102, 106, 101, 105, 103, 107};
    lit_im = '{200, 204, 202, 206, 201, 205, 203, 207};
    for (int k = 0; k < 8; k++) begin
      f_re[k*W +: W] = W'(100 + k);
      f_im[k*W +: W] = W'(200 + k);
    end
    clear_logs();
    stim_re.push_back(f_re); stim_im.push_back(f_im);
    applyStimulus(0, -1, 50);
    checkOutput("bitrev_beats", 64'(obs_re.size()), 64'd8);
    if (obs_re.size() == 8 && acc_cyc.size() == 1) begin
      checkOutput("bitrev_latency", 64'(obs_cyc[0] - acc_cyc[0]), 64'd1);
      checkOutput("bitrev_gapless", 64'(obs_cyc[7] - obs_cyc[0]), 64'd7);
      for (int i = 0; i < 8; i++) begin
        checkOutput("bitrev_real", 64'(obs_re[i]), 64'(lit_re[i]));
        checkOutput("bitrev_imag", 64'(obs_im[i]), 64'(lit_im[i]));
      end
    end

    $display("[TB] back-to-back frames");
    clear_logs();
    f2_re = '0;
    for (int f = 0; f < 3; f++) begin
      f_re = rnd_frame(); f_im = rnd_frame();
      if (f == 1) f2_re = f_re;
      stim_re.push_back(f_re); stim_im.push_back(f_im);
    end
    applyStimulus(0, -1, 100);
    checkOutput("b2b_accepts", 64'(acc_cyc.size()), 64'd3);
    checkOutput("b2b_beats",   64'(obs_re.size()),  64'd24);
    if (acc_cyc.size() == 3 && obs_re.size() == 24) begin
      checkOutput("b2b_second_accept", 64'(acc_cyc[1] - acc_cyc[0]), 64'd1);
      checkOutput("b2b_third_accept",  64'(acc_cyc[2] - acc_cyc[0]), 64'd9);
      checkOutput("b2b_gapless",       64'(obs_cyc[23] - obs_cyc[0]), 64'd23);
      checkOutput("b2b_frame2_bin0",   64'(obs_re[8]), 64'(f2_re[0 +: W]));
      checkOutput("b2b_frame2_bin1",   64'(obs_re[9]), 64'(f2_re[4*W +: W]));
    end

    $display("[TB] backpressure pattern");
    clear_logs();
    pat_idx = 0;
    for (int f = 0; f < 3; f++) begin
      stim_re.push_back(rnd_frame()); stim_im.push_back(rnd_frame());
    end
    applyStimulus(1, -1, 200);
    checkOutput("bp_beats",   64'(obs_re.size()),  64'd24);
    checkOutput("bp_accepts", 64'(acc_cyc.size()), 64'd3);

    $display("[TB] random traffic");
    clear_logs();
    for (int f = 0; f < 12; f++) begin
      stim_re.push_back(rnd_frame()); stim_im.push_back(rnd_frame());
    end
    applyStimulus(2, -1, 1500);
    checkOutput("rand_beats", 64'(obs_re.size()), 64'd96);

    $display("[TB] reset mid-frame");
    stim_re.push_back(rnd_frame()); stim_im.push_back(rnd_frame());
    applyStimulus(0, 4, 50);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_out_real",  64'(out_real),  64'd0);
    checkOutput("midrst_out_imag",  64'(out_imag),  64'd0);
    checkOutput("midrst_out_index", 64'(out_index), 64'd0);
    checkOutput("midrst_in_ready",  64'(in_ready),  64'd0);
    stim_re.delete(); stim_im.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("postrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    clear_logs();
    for (int k = 0; k < 8; k++) begin
      f_re[k*W +: W] = W'(500 + k);
      f_im[k*W +: W] = W'(600 + k);
    end
    stim_re.push_back(f_re); stim_im.push_back(f_im);
    applyStimulus(0, -1, 50);
    checkOutput("postrst_beats", 64'(obs_re.size()), 64'd8);
    if (obs_re.size() == 8) begin
      checkOutput("postrst_bin0_real", 64'(obs_re[0]), 64'd500);
      checkOutput("postrst_bin0_imag", 64'(obs_im[0]), 64'd600);
      checkOutput("postrst_bin1_real", 64'(obs_re[1]), 64'd504);
    end

    $display("[TB] direct order, 16-bit");
    lit_n = '{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC, 16'hFFFB, 16'hFFFA, 16'hFFF9, 16'hFFF8};
    for (int k = 0; k < 8; k++) begin
      n_in_real[k*NW +: NW] = NW'(-(k + 1));
      n_in_imag[k*NW +: NW] = NW'(k);
    end
    checkOutput("narrow_in_ready", 64'(n_in_ready), 64'd1);
    n_in_valid = 1'b1;
    @(posedge clk);
    #1;
    n_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput("narrow_valid", 64'(n_out_valid), 64'd1);
      checkOutput("narrow_real",  64'(n_out_real),  64'(lit_n[i]));
      checkOutput("narrow_imag",  64'(n_out_imag),  64'(i));
      checkOutput("narrow_index", 64'(n_out_index), 64'(i));
      checkOutput("narrow_last",  64'(n_out_last),  64'(i == 7));
      @(posedge clk);
      #1;
    end
    checkOutput("narrow_drained", 64'(n_out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft8_result_unloader.md
# fft8_result_unloader

Streaming reader for the 8-point radix-2 DIF FFT core (`butterfly8`). It captures one full parallel frame of 8 complex results per handshake. It then emits the frame one complex sample per beat over a valid/ready stream, in natural frequency order, undoing the DIF bit-reversed output ordering. Two internal frame banks (ping-pong) let the FFT side hand over the next frame while the current one is still draining, so sustained throughput is one frame per 8 cycles.

## Interface
- `DATA_W`, 32: width of each real and imaginary component (two's complement, passed through unmodified).
- `BITREV`, 1: 1 selects bit-reversed lane readout (DIF order to natural order); 0 selects direct lane order.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  a full 8-lane frame is presented on `in_real`/`in_imag`.
- `in_ready`  out  1  a bank is free; the frame is captured on `in_valid && in_ready`.
- `in_real`  in  8*DATA_W  lane k real part at bits [k*DATA_W +: DATA_W] (lane k = `butterfly8` output `c_real<k>`).
- `in_imag`  in  8*DATA_W  lane k imaginary part at the same bit positions as `in_real`.
- `out_valid`  out  1  the output beat is valid.
- `out_ready`  in  1  downstream accepts; a beat transfers on `out_valid && out_ready`.
- `out_real`  out  DATA_W  real part of the current beat.
- `out_imag`  out  DATA_W  imaginary part of the current beat.
- `out_index`  out  3  natural-order bin number k of the current beat.
- `out_last`  out  1  high on the beat with `out_index` = 7.

## Operation
- **Storage:**
  - Two banks, each holding 8 × (real, imag) registers.
  - Per-bank `full` flags.
  - Write pointer `wp` and read pointer `rp` (1 bit each).
  - 3-bit beat counter `beat`.
- **Capture:**
  - On `in_valid && in_ready`, all 16 words are written into bank `wp`, `full[wp]` is set and `wp` toggles.
  - `in_ready` = `!full[wp]`, taken from registers only. There is no combinational path from `out_ready` to `in_ready`.
- **Readout:**
  - `out_valid` = `full[rp]`.
  - `out_index` = `beat`.
  - Data comes from bank `rp`, lane L, where L = bitrev3(`beat`) when `BITREV`=1 and L = `beat` otherwise.
  - Bit-reverse map: 0→0, 1→4, 2→2, 3→6, 4→1, 5→5, 6→3, 7→7.
- **Handshake:**
  - Each output handshake increments `beat`.
  - On the handshake with `beat` = 7: `beat` wraps to 0, `full[rp]` clears and `rp` toggles.
- **Stall:** while `out_valid && !out_ready`, `out_real`, `out_imag`, `out_index` and `out_last` hold stable.
- **Bank state machine (per bank):** EMPTY → FULL on capture; FULL → EMPTY on the last-beat handshake. No other transitions.
- **Same bank in one cycle:** a capture and a last-beat release can never hit the same bank in one cycle, because capture requires `full[wp]` = 0.
- **Release while full:**
  - Condition: both banks FULL and the last beat handshakes.
  - That cycle `in_ready` stays 0.
  - It rises on the next cycle.
- **Simultaneous capture and release on different banks:** both take effect in the same edge.
- **Data path:** pure register and mux. No arithmetic, rounding, scaling or sign change.
- **Reset** (asynchronous, takes effect immediately):
  - All `full` flags, `wp`, `rp` and `beat` go to 0.
  - Bank contents go to 0.
  - Outputs: `out_valid`=0, `out_real`=0, `out_imag`=0, `out_index`=0, `out_last`=0.
  - `in_ready` is forced to 0 while `rst` is high and is 1 on the first cycle after release.
  - A frame in progress at reset is discarded. The next frame starts at `out_index` 0.

## Timing
- Capture to first beat: the frame captured at edge N has `out_valid`=1 after edge N (latency 1 cycle).
- With `out_ready` held at 1, the 8 beats occupy 8 consecutive cycles.
- Back-to-back frames: the next bank's beat 0 follows beat 7 with no bubble.
- Sustained input acceptance: one frame per 8 cycles. `in_ready` may accept two frames back-to-back after idle, filling both banks.
- All outputs are driven from registers through a lane mux; no input feeds an output combinationally except through the registers.

## Test plan
- **Bit-reverse order:** `BITREV`=1, single frame with lane k real=100+k and imag=200+k, `out_ready`=1.
  - One cycle after capture, 8 consecutive beats appear with real 100, 104, 102, 106, 101, 105, 103, 107 and imag 200, 204, 202, 206, 201, 205, 203, 207.
  - `out_index` runs 0..7 and `out_last` is high only on the 8th beat.
- **Back-to-back frames:** three frames offered back-to-back, `out_ready`=1.
  - Frames 1 and 2 are accepted on consecutive cycles.
  - `in_ready` drops, then frame 3 is accepted in the cycle after frame 1's last beat.
  - 24 gapless beats are output in frame order.
- **Backpressure:** `out_ready` pattern 1,0,0,1,0,1,…
  - Every beat's data and index hold stable across stalls.
  - No beat is lost or duplicated; exactly 8 handshakes per frame.
- **Both banks full:** both banks full and the last beat handshakes with `in_valid`=1.
  - `in_ready`=0 in that cycle.
  - `in_ready`=1 next cycle; the frame is captured then.
  - The next frame streams with no gap after the old one.
- **Reset mid-frame:** assert `rst` after beat 3 of a frame.
  - `out_valid`, `out_real`, `out_imag` and `out_index` are 0 immediately, before the next edge.
  - After release `in_ready`=1; the next captured frame starts at index 0 with its own data.
- **Direct order, narrow width:** `DATA_W`=16, `BITREV`=0, lane k real=−(k+1), imag=k.
  - Output real is 16'hFFFF, 16'hFFFE, …, 16'hFFF8 in lane order.
  - Output imag is 0..7.
